sc_number_gen: RTL

Stochastic number generator (SNG) that sits directly downstream of the 10-bit maximal-length LFSR in the stochastic system. It accepts one binary operand per transaction over a valid/ready handshake. For STREAM_LEN consecutive cycles it compares the operand against the free-running LFSR word and emits a unary bitstream whose count of ones encodes the operand. It also counts the ones it emits, so the bitstream and the count can be checked against each other in the same run.

---
 rtl/sc_pkg.sv | 13 +
 rtl/sc_len_counter.sv | 32 +++
 rtl/sc_number_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: default widths and the
// stream-generator state type.
package sc_pkg;

    localparam int unsigned SC_WIDTH      = 10;
    localparam int unsigned SC_STREAM_LEN = 1023;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } sc_state_e;

endpackage

// File: rtl/sc_len_counter.sv
// Stream-length up-counter with synchronous clear, count enable and a terminal-count
// flag that is high while the count sits on LEN-1.
module sc_len_counter #(
    parameter int unsigned LEN   = 1023,
    parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/sc_number_gen.sv
// Stochastic number generator: compares a latched operand against the free-running
// LFSR word for one full LFSR period, emitting a unary bitstream and its ones count.
module sc_number_gen
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH      = SC_WIDTH,
    parameter int unsigned STREAM_LEN = SC_STREAM_LEN,
    localparam int unsigned CNT_W     = $clog2(STREAM_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [WIDTH-1:0] rand_in,
    output logic             sc_bit,
    output logic             sc_valid,
    output logic             sc_last,
    output logic [CNT_W-1:0] ones_count,
    output logic             done
);

    sc_state_e        r_state;
    logic [WIDTH-1:0] r_value;
    logic             r_sc_bit;
    logic             r_sc_valid;
    logic             r_last;
    logic [CNT_W-1:0] r_ones;

    logic             w_accept;
    logic             w_run;
    logic             w_bit;
    logic             w_tc;
    logic [CNT_W-1:0] w_bit_cnt;

    assign in_ready = (r_state == StIdle);
    assign w_accept = in_valid && in_ready;
    assign w_run    = (r_state == StRun);
    assign w_bit    = (rand_in <= r_value);

    sc_len_counter #(
        .LEN   (STREAM_LEN),
        .CNT_W (CNT_W)
    ) u_len_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_en    (w_run),
        .o_count (w_bit_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_value    <= '0;
            r_sc_bit   <= 1'b0;
            r_sc_valid <= 1'b0;
            r_last     <= 1'b0;
            r_ones     <= '0;
        end else begin
            r_last <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_sc_bit   <= 1'b0;
                    r_sc_valid <= 1'b0;
                    if (in_valid) begin
                        r_value <= in_value;
                        r_ones  <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sc_bit   <= w_bit;
                    r_sc_valid <= 1'b1;
                    r_ones     <= r_ones + CNT_W'(w_bit);
                    if (w_tc) begin
                        r_last  <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // The bit counter parks at STREAM_LEN between streams and never goes past it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_bit_cnt <= CNT_W'(STREAM_LEN));
        end
    end

    assign sc_bit     = r_sc_bit;
    assign sc_valid   = r_sc_valid;
    assign sc_last    = r_last;
    assign done       = r_last;
    assign ones_count = r_ones;

endmodule
